// File: rtl/bg_cal_sched.sv
// bg_cal_sched: bandgap SAR calibration scheduler that averages 2^AVG_LOG2 conversions,
// publishes the trim code, sleeps between runs and flags drift and valid timeouts.
module bg_cal_sched #(
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD   = 100000,
    parameter int TIMEOUT  = 2000,
    parameter int DRIFT_TH = 4,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       force_cal,
    input  logic       clr_drift,
    input  logic       bg_valid,
    input  logic [7:0] bg_idac_coarse,
    input  logic [7:0] bg_idac_fine,
    output logic       bg_pwrup,
    output logic [7:0] trim_coarse,
    output logic [7:0] trim_fine,
    output logic       trim_valid,
    output logic       result_update,
    output logic       busy,
    output logic       drift_flag,
    output logic       timeout_err,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE, RUN, SLEEP, ERROR} state_t;
    localparam int AW = 16 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CTR_TO = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CTR_PER = CNT_W'(PERIOD - 1);
    localparam logic [15:0] TH = 16'(DRIFT_TH);

    state_t cur, nxt;
    logic valid_q, accept, last, timeout_hit, drift_hit;
    logic [AW-1:0] acc, sum;
    logic [AVG_LOG2:0] cnt;
    logic [CNT_W-1:0] ctr;
    logic [15:0] code, avg, prev, diff;

    assign state = cur;
    assign code = {bg_idac_coarse, bg_idac_fine};
    assign prev = {trim_coarse, trim_fine};
    assign sum = acc + AW'(code);
    assign avg = 16'(sum >> AVG_LOG2);
    assign diff = avg > prev ? avg - prev : prev - avg;
    // a rising valid only counts while RUN is not being abandoned by enable=0
    assign accept = cur == RUN && enable && bg_valid && !valid_q;
    assign last = accept && cnt == CNT_LAST;
    assign timeout_hit = cur == RUN && !accept && ctr == CTR_TO;
    assign drift_hit = last && trim_valid && diff > TH;

    always_comb begin
        nxt = cur;
        if (!enable)
            nxt = IDLE;
        else
            case (cur)
                IDLE:    nxt = RUN;
                RUN:     nxt = last ? SLEEP : timeout_hit ? ERROR : RUN;
                SLEEP:   nxt = (ctr == CTR_PER || force_cal) ? RUN : SLEEP;
                default: nxt = ERROR;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= IDLE;
            valid_q <= 1'b0;
            acc <= '0;
            cnt <= '0;
            ctr <= '0;
            bg_pwrup <= 1'b0;
            busy <= 1'b0;
            timeout_err <= 1'b0;
            result_update <= 1'b0;
            trim_valid <= 1'b0;
            trim_coarse <= 8'h00;
            trim_fine <= 8'h00;
            drift_flag <= 1'b0;
        end else begin
            cur <= nxt;
            valid_q <= bg_valid;
            bg_pwrup <= nxt == RUN;
            busy <= nxt == RUN;
            timeout_err <= nxt == ERROR;
            result_update <= last;
            drift_flag <= drift_hit | (drift_flag & ~clr_drift);
            if (last) begin
                trim_coarse <= avg[15:8];
                trim_fine <= avg[7:0];
            end
            trim_valid <= enable && (trim_valid || last);
            // every state change starts the next phase from a clean slate
            if (nxt != cur) begin
                acc <= '0;
                cnt <= '0;
                ctr <= '0;
            end else if (cur == RUN && accept) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                ctr <= '0;
            end else if (cur == RUN || cur == SLEEP) begin
                ctr <= ctr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bg_cal_sched.sv
// tb_bg_cal_sched: directed tests for bg_cal_sched with AVG_LOG2=2, PERIOD=50, TIMEOUT=20, DRIFT_TH=4.
module tb_bg_cal_sched;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, force_cal = 1'b0, clr_drift = 1'b0, bg_valid = 1'b0;
    logic [7:0] bg_idac_coarse = 8'h00, bg_idac_fine = 8'h00;
    logic bg_pwrup, trim_valid, result_update, busy, drift_flag, timeout_err;
    logic [7:0] trim_coarse, trim_fine;
    logic [1:0] state;
    int total = 0, bad = 0, pub_cnt = 0;

    bg_cal_sched #(.AVG_LOG2(2), .PERIOD(50), .TIMEOUT(20), .DRIFT_TH(4), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .enable(enable), .force_cal(force_cal), .clr_drift(clr_drift),
        .bg_valid(bg_valid), .bg_idac_coarse(bg_idac_coarse), .bg_idac_fine(bg_idac_fine),
        .bg_pwrup(bg_pwrup), .trim_coarse(trim_coarse), .trim_fine(trim_fine), .trim_valid(trim_valid),
        .result_update(result_update), .busy(busy), .drift_flag(drift_flag), .timeout_err(timeout_err),
        .state(state));

    always #50 clk = ~clk;
    always @(negedge clk) if (result_update === 1'b1) pub_cnt <= pub_cnt + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] code, input int hold);
        bg_idac_coarse = code[15:8];
        bg_idac_fine = code[7:0];
        bg_valid = 1'b1;
        repeat (hold) step();
        bg_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if ({state, bg_pwrup, busy, trim_valid, result_update, drift_flag, timeout_err, trim_coarse, trim_fine} !== 24'h0) begin
            bad++;
            $display("FAIL reset: got st=%0d pw=%b bz=%b tv=%b ru=%b df=%b te=%b trim=%h%h exp all zero",
                     state, bg_pwrup, busy, trim_valid, result_update, drift_flag, timeout_err, trim_coarse, trim_fine);
        end
        reset = 1'b0;
    endtask

    task automatic test_avg();
        enable = 1'b1;
        step();
        total++;
        if (state !== 2'd1 || bg_pwrup !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL enter_run: got st=%0d pw=%b bz=%b exp 1 1 1", state, bg_pwrup, busy);
        end
        feed(16'h8010, 1);
        feed(16'h8012, 1);
        feed(16'h8014, 1);
        bg_idac_coarse = 8'h80;
        bg_idac_fine = 8'h17;
        bg_valid = 1'b1;
        step();
        total++;
        if ({trim_coarse, trim_fine} !== 16'h8013 || result_update !== 1'b1 || state !== 2'd2 || bg_pwrup !== 1'b0 || trim_valid !== 1'b1) begin
            bad++;
            $display("FAIL publish: got trim=%h%h ru=%b st=%0d pw=%b tv=%b exp 8013 1 2 0 1",
                     trim_coarse, trim_fine, result_update, state, bg_pwrup, trim_valid);
        end
        bg_valid = 1'b0;
        step();
        total++;
        if (result_update !== 1'b0 || drift_flag !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: got ru=%b df=%b exp 0 0", result_update, drift_flag);
        end
    endtask

    task automatic test_period();
        int n = 2;
        while (state === 2'd2 && n < 200) begin
            step();
            if (state === 2'd2) n++;
        end
        total++;
        if (n !== 50 || state !== 2'd1 || bg_pwrup !== 1'b1) begin
            bad++;
            $display("FAIL sleep_period: got cycles=%0d st=%0d pw=%b exp 50 1 1", n, state, bg_pwrup);
        end
    endtask

    task automatic run4(input logic [15:0] code);
        repeat (4) feed(code, 1);
    endtask

    task automatic test_drift();
        run4(16'h8017);
        total++;
        if ({trim_coarse, trim_fine} !== 16'h8017 || drift_flag !== 1'b0 || state !== 2'd2) begin
            bad++;
            $display("FAIL drift_eq_th: got trim=%h%h df=%b st=%0d exp 8017 0 2", trim_coarse, trim_fine, drift_flag, state);
        end
        repeat (8) step();
        force_cal = 1'b1;
        step();
        force_cal = 1'b0;
        total++;
        if (state !== 2'd1 || bg_pwrup !== 1'b1) begin
            bad++;
            $display("FAIL force_cal: got st=%0d pw=%b exp 1 1", state, bg_pwrup);
        end
        run4(16'h801C);
        total++;
        if ({trim_coarse, trim_fine} !== 16'h801C || drift_flag !== 1'b1) begin
            bad++;
            $display("FAIL drift_gt_th: got trim=%h%h df=%b exp 801c 1", trim_coarse, trim_fine, drift_flag);
        end
    endtask

    task automatic test_held();
        int base;
        force_cal = 1'b1;
        step();
        force_cal = 1'b0;
        base = pub_cnt;
        feed(16'h801C, 3);
        feed(16'h801C, 3);
        total++;
        if (pub_cnt - base !== 0 || state !== 2'd1) begin
            bad++;
            $display("FAIL held_partial: got pubs=%0d st=%0d exp 0 1", pub_cnt - base, state);
        end
        feed(16'h801C, 3);
        feed(16'h801C, 3);
        step();
        total++;
        if (pub_cnt - base !== 1 || state !== 2'd2 || {trim_coarse, trim_fine} !== 16'h801C) begin
            bad++;
            $display("FAIL held_full: got pubs=%0d st=%0d trim=%h%h exp 1 2 801c", pub_cnt - base, state, trim_coarse, trim_fine);
        end
    endtask

    task automatic test_clr();
        clr_drift = 1'b1;
        step();
        clr_drift = 1'b0;
        total++;
        if (drift_flag !== 1'b0) begin
            bad++;
            $display("FAIL clr_drift: got df=%b exp 0", drift_flag);
        end
        force_cal = 1'b1;
        step();
        force_cal = 1'b0;
        repeat (3) feed(16'h8010, 1);
        bg_valid = 1'b1;
        clr_drift = 1'b1;
        step();
        bg_valid = 1'b0;
        clr_drift = 1'b0;
        total++;
        if (drift_flag !== 1'b1 || result_update !== 1'b1 || {trim_coarse, trim_fine} !== 16'h8010) begin
            bad++;
            $display("FAIL set_beats_clr: got df=%b ru=%b trim=%h%h exp 1 1 8010", drift_flag, result_update, trim_coarse, trim_fine);
        end
    endtask

    task automatic test_timeout();
        int n = 1;
        force_cal = 1'b1;
        step();
        force_cal = 1'b0;
        while (state === 2'd1 && n < 200) begin
            step();
            if (state === 2'd1) n++;
        end
        total++;
        if (n !== 20 || state !== 2'd3 || timeout_err !== 1'b1 || bg_pwrup !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout: got cycles=%0d st=%0d te=%b pw=%b bz=%b exp 20 3 1 0 0", n, state, timeout_err, bg_pwrup, busy);
        end
        repeat (3) step();
        total++;
        if (state !== 2'd3 || {trim_coarse, trim_fine} !== 16'h8010) begin
            bad++;
            $display("FAIL error_hold: got st=%0d trim=%h%h exp 3 8010", state, trim_coarse, trim_fine);
        end
        enable = 1'b0;
        step();
        total++;
        if (state !== 2'd0 || timeout_err !== 1'b0 || trim_valid !== 1'b0) begin
            bad++;
            $display("FAIL error_exit: got st=%0d te=%b tv=%b exp 0 0 0", state, timeout_err, trim_valid);
        end
        enable = 1'b1;
        step();
        repeat (19) step();
        feed(16'h9000, 1);
        total++;
        if (state !== 2'd1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL sample_at_limit: got st=%0d te=%b exp 1 0", state, timeout_err);
        end
    endtask

    task automatic test_enable_drop();
        feed(16'h9000, 1);
        enable = 1'b0;
        step();
        total++;
        if (state !== 2'd0 || bg_pwrup !== 1'b0 || trim_valid !== 1'b0 || {trim_coarse, trim_fine} !== 16'h8010 || drift_flag !== 1'b1) begin
            bad++;
            $display("FAIL enable_drop: got st=%0d pw=%b tv=%b trim=%h%h df=%b exp 0 0 0 8010 1",
                     state, bg_pwrup, trim_valid, trim_coarse, trim_fine, drift_flag);
        end
        enable = 1'b1;
        step();
        feed(16'h7000, 1);
        feed(16'h7004, 1);
        feed(16'h7008, 1);
        feed(16'h700C, 1);
        total++;
        if ({trim_coarse, trim_fine} !== 16'h7006 || trim_valid !== 1'b1 || state !== 2'd2) begin
            bad++;
            $display("FAIL fresh_avg: got trim=%h%h tv=%b st=%0d exp 7006 1 2", trim_coarse, trim_fine, trim_valid, state);
        end
    endtask

    task automatic test_reset_sleep();
        reset = 1'b1;
        enable = 1'b0;
        step();
        total++;
        if ({state, bg_pwrup, busy, trim_valid, result_update, drift_flag, timeout_err, trim_coarse, trim_fine} !== 24'h0) begin
            bad++;
            $display("FAIL reset_sleep: got st=%0d pw=%b bz=%b tv=%b ru=%b df=%b te=%b trim=%h%h exp all zero",
                     state, bg_pwrup, busy, trim_valid, result_update, drift_flag, timeout_err, trim_coarse, trim_fine);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_avg();
        test_period();
        test_drift();
        test_held();
        test_clr();
        test_timeout();
        test_enable_drop();
        test_reset_sleep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bg_cal_sched.md
Name: bg_cal_sched

Overview:
Calibration scheduler for the bandgap SAR trim controller. It powers the SAR loop up, collects 2^AVG_LOG2 conversion results from its valid pulses, and publishes the averaged 16-bit trim code. It then powers the loop down and re-runs calibration periodically or on demand. It also flags drift between successive results and a missing-valid timeout. Sits between the top-level enable/control registers and the SAR controller's pwrup/valid/idac outputs, on the same 10 MHz clock.

Parameters:
AVG_LOG2, 2, log2 of conversions averaged per calibration (0..4)
PERIOD, 100000, cycles spent in SLEEP between calibrations (10 ms at 10 MHz)
TIMEOUT, 2000, max cycles allowed between RUN entry or last sample and the next valid edge
DRIFT_TH, 4, max allowed |new - previous| 16-bit result before drift_flag sets
CNT_W, 20, width of the shared period/timeout counter; must hold max(PERIOD, TIMEOUT)

Ports:
clk  in  1  system clock, 10 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = scheduler active, 0 = force IDLE
force_cal  in  1  1-cycle pulse; in SLEEP, start calibration immediately
clr_drift  in  1  1-cycle pulse; clears drift_flag
bg_valid  in  1  valid from SAR controller; may stay high for several cycles
bg_idac_coarse  in  8  SAR coarse code
bg_idac_fine  in  8  SAR fine code
bg_pwrup  out  1  pwrup to SAR controller
trim_coarse  out  8  averaged result [15:8]
trim_fine  out  8  averaged result [7:0]
trim_valid  out  1  a result has been published since enable rose
result_update  out  1  1-cycle pulse when trim_* is updated
busy  out  1  1 in RUN
drift_flag  out  1  sticky drift indication
timeout_err  out  1  1 in ERROR
state  out  2  IDLE=0, RUN=1, SLEEP=2, ERROR=3

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on the reset port. All outputs are registered.
- Reset values: state=IDLE; bg_pwrup, trim_valid, result_update, busy, drift_flag and timeout_err all 0; trim_coarse=trim_fine=0. Internal accumulator, sample count, counter and previous result are all 0; valid_q=0.
- Edge detection: sample = bg_valid & ~valid_q, where valid_q is bg_valid registered every cycle. A sample is accepted only in RUN, and only when the FSM is not transitioning away that same cycle.
- IDLE: bg_pwrup=0. If enable=1, go to RUN next cycle; clear accumulator, sample count and counter.
- RUN: bg_pwrup=1, busy=1.
  - On each accepted sample: acc += {coarse,fine}; count++; counter cleared.
  - Otherwise counter++.
  - Accumulator width is 16+AVG_LOG2; no overflow is possible.
  - On the 2^AVG_LOG2-th sample: next cycle, trim = acc_final >> AVG_LOG2 (truncating), result_update=1 for 1 cycle, trim_valid=1, state=SLEEP, bg_pwrup=0. Accumulator, sample count and counter are cleared.
- Timeout: if counter reaches TIMEOUT-1 in RUN with no sample that cycle, go to ERROR. If a sample and the timeout occur in the same cycle, the sample wins.
- SLEEP: bg_pwrup=0; counter++.
  - When counter == PERIOD-1, or when force_cal=1, go to RUN with counter cleared.
  - force_cal outside SLEEP is ignored.
- ERROR: bg_pwrup=0, timeout_err=1. Exits only via enable=0, which goes to IDLE. trim_* hold their values.
- Drift: on each publish after the first since enable rose, compare the new and previous 16-bit results. If |diff| > DRIFT_TH, set drift_flag. The previous result is then updated to the new one.
  - clr_drift clears drift_flag. If set and clear occur in the same cycle, set wins.
  - drift_flag is not cleared by enable.
- enable=0 (any state, including mid-RUN): next cycle state=IDLE, bg_pwrup=0, trim_valid=0, timeout_err=0. A partial accumulation is discarded; trim_* retain their last values. enable=0 has priority over all other events.
- Reset mid-operation: all state returns to the reset values on the next edge, regardless of state.

Test Plan:
- AVG_LOG2=2: enable=1, feed 4 valid pulses with codes 0x8010, 0x8012, 0x8014, 0x8017 -> trim=0x8013, result_update for 1 cycle, state=SLEEP, bg_pwrup=0 the same cycle.
- Valid held high for 3 cycles -> counted as 1 sample; 4 such pulses -> exactly one publish.
- PERIOD=50: after a publish, SLEEP lasts 50 cycles, then RUN with bg_pwrup=1. A force_cal at SLEEP cycle 10 -> RUN on the next cycle.
- TIMEOUT=20, no valid in RUN -> ERROR after 20 cycles, timeout_err=1, bg_pwrup=0. Then enable=0 -> IDLE, timeout_err=0. A sample on exactly cycle 20 -> no error.
- Drift with DRIFT_TH=4: result 0x8013 then 0x8018 (diff 5) -> drift_flag=1. Results 0x8013 then 0x8017 (diff 4) -> flag stays 0. clr_drift together with a new drift event -> flag stays 1.
- enable=0 after 2 of 4 samples -> IDLE next cycle, trim_* unchanged, trim_valid=0. Re-enable -> a fresh 4-sample average with no stale accumulation. Reset asserted in SLEEP -> all outputs at reset values.
